seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised iterative radix-2 restoring divider: next generation of the 24-bit gate-level divider.
- Generalises width; adds signed mode, a START/BUSY/DONE handshake, divide-by-zero detection, a remainder output and a deterministic latency.
- Sits beside the datapath blocks as a shared multi-cycle arithmetic unit, clock-gated through E.

Parameters:
C_NUM_BITS, 24, operand/result width in bits (legal range 4..64).
C_CNT_BITS, $clog2(C_NUM_BITS+1), iteration counter width (derived; do not override).

Ports:
CK     in   1           clock, rising edge.
R      in   1           reset; one clock; reset is asynchronous and active-high.
E      in   1           clock enable; low freezes every register, DONE included.
START  in   1           request; sampled only in IDLE with E=1.
SGN    in   1           1 = two's-complement operands; 0 = unsigned. Captured with START.
A      in   C_NUM_BITS  dividend, captured with START.
B      in   C_NUM_BITS  divisor, captured with START.
BUSY   out  1           high from the START-accept edge until the edge that raises DONE.
DONE   out  1           one enabled-cycle pulse; Q/REM/DZ are valid while high and held afterwards.
Q      out  C_NUM_BITS  quotient.
REM    out  C_NUM_BITS  remainder.
DZ     out  1           divide-by-zero flag for the current result.

Behaviour:
- Reset (R=1, asynchronous): state IDLE, counter 0, Q=0, REM=0, DZ=0, DONE=0, BUSY=0.
- Reset mid-operation aborts the operation; no DONE is produced.
- All state advances only on CK edges with E=1.
- States:
  - IDLE: START=1 at edge k captures the operands, the sign of A, sign(A) xor sign(B), and |A|,|B| (magnitudes only when SGN=1). Sets BUSY=1. If B==0, next state is FIX; otherwise RUN with counter=0.
  - RUN: one restoring step per edge. Partial remainder P (C_NUM_BITS+1 bits) = {P, dividend MSB}, then trial = P - |B|. If trial is non-negative, P = trial and the quotient bit is 1; otherwise P is kept and the bit is 0. The dividend register shifts left and takes the quotient bit. The counter increments. At counter == C_NUM_BITS-1 the next state is FIX.
  - FIX: registers Q and REM with sign correction. Q is negated if the captured sign-xor is 1; REM is negated if the captured sign of A is 1 (truncating division). Sets DONE=1, BUSY=0, next state IDLE.
- DONE clears at the next enabled edge.
- Latency:
  - Normal: DONE is high after edge k+C_NUM_BITS+1 (25 edges for 24 bits).
  - Divide-by-zero: DONE is high after edge k+1.
- Divide-by-zero result: Q = all ones, REM = A unchanged, DZ=1. Otherwise DZ=0.
- Signed overflow (most-negative / -1): Q = most-negative, REM = 0, DZ=0. This falls out of the magnitude algorithm; no special case.
- START while BUSY=1 is ignored (no queueing).
- START at the same edge as DONE falling is accepted: IDLE was entered at the FIX edge.
- A/B/SGN changes after capture have no effect.
- Q/REM/DZ hold their values between DONE pulses; the internal working registers are not visible on Q/REM.

Decomposition:
- Package seq_divider_pkg holds:
  - state enum {IDLE, RUN, FIX} (2-bit);
  - function for the counter width;
  - localparam for the all-ones quotient.
- Sub-module div_step: combinational single restoring iteration, parametrised by C_NUM_BITS. Inputs: P, dividend MSB, |B|. Outputs: next P and the quotient bit.
- Top module: FSM, counter, operand/sign registers, output registers.

Test Plan:
- Unsigned, N=24, SGN=0, A=100, B=7, START at edge k -> DONE high after edge k+25; Q=14, REM=2, DZ=0; BUSY high for exactly 25 edges.
- Signed, SGN=1, A=-100 (0xFFFF9C), B=7 -> Q=-14 (0xFFFFF2), REM=-2 (0xFFFFFE). Then A=100, B=-7 -> Q=0xFFFFF2, REM=2.
- Edge values:
  - A=0x123456, B=0 -> DONE after edge k+1; Q=0xFFFFFF, REM=0x123456, DZ=1.
  - SGN=1, A=0x800000, B=0xFFFFFF -> Q=0x800000, REM=0.
  - SGN=0, A=0xFFFFFF, B=1 -> Q=0xFFFFFF, REM=0.
- E held low for 5 cycles mid-RUN -> DONE delayed by exactly 5 cycles with unchanged result. E low in the DONE cycle -> DONE stays high until the next enabled edge.
- START pulsed during RUN with different A/B -> ignored; first result correct; no second DONE.
- R asserted mid-RUN -> all outputs 0 immediately; no DONE. A new START after release -> correct result.
- Parameter sweep C_NUM_BITS=8 -> random signed/unsigned pairs match a reference model; latency = 9 edges.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the iterative divider
//
// Contents:
//   state_t       FSM state encoding (IDLE, RUN, FIX)
//   C_Q_ALL_ONES  quotient pattern returned on divide-by-zero (sliced to width)
//   cnt_bits()    iteration counter width for a given operand width
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int unsigned C_MAX_BITS = 64;

  // Widest supported all-ones quotient; users slice the low C_NUM_BITS bits.
  localparam logic [C_MAX_BITS-1:0] C_Q_ALL_ONES = '1;

  // Counter must hold the value C_NUM_BITS.
  function automatic int cnt_bits(input int num_bits);
    return $clog2(num_bits + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   p       in   C_NUM_BITS  current partial remainder (always < b)
//   msb     in   1           next dividend bit shifted into the remainder
//   b       in   C_NUM_BITS  divisor magnitude
//   p_next  out  C_NUM_BITS  partial remainder after this step
//   q_bit   out  1           quotient bit produced by this step
module div_step #(
  parameter int C_NUM_BITS = 24
) (
  input  logic [C_NUM_BITS-1:0] p,
  input  logic                  msb,
  input  logic [C_NUM_BITS-1:0] b,
  output logic [C_NUM_BITS-1:0] p_next,
  output logic                  q_bit
);

  logic [C_NUM_BITS:0]   shifted;
  logic [C_NUM_BITS-1:0] trial;

  assign shifted = {p, msb};

  // When the subtraction succeeds the result is below b, so the low
  // C_NUM_BITS bits of the difference are exact.
  assign trial  = shifted[C_NUM_BITS-1:0] - b;
  assign q_bit  = (shifted >= {1'b0, b});
  assign p_next = q_bit ? trial : shifted[C_NUM_BITS-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider, signed/unsigned
//
// Ports:
//   CK     in   1           clock, rising edge
//   R      in   1           asynchronous active-high reset
//   E      in   1           clock enable; low freezes all registers
//   START  in   1           request, accepted only in IDLE
//   SGN    in   1           1 = two's-complement operands
//   A      in   C_NUM_BITS  dividend
//   B      in   C_NUM_BITS  divisor
//   BUSY   out  1           operation in progress
//   DONE   out  1           one enabled-cycle result strobe
//   Q      out  C_NUM_BITS  quotient (held between results)
//   REM    out  C_NUM_BITS  remainder (held between results)
//   DZ     out  1           divide-by-zero flag for the current result
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int C_NUM_BITS = 24,
  localparam int C_CNT_BITS = cnt_bits(C_NUM_BITS)
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  E,
  input  logic                  START,
  input  logic                  SGN,
  input  logic [C_NUM_BITS-1:0] A,
  input  logic [C_NUM_BITS-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [C_NUM_BITS-1:0] Q,
  output logic [C_NUM_BITS-1:0] REM,
  output logic                  DZ
);

  localparam logic [C_CNT_BITS-1:0] C_LAST = C_CNT_BITS'(C_NUM_BITS - 1);

  state_t                state;
  logic [C_CNT_BITS-1:0] cnt;
  logic [C_NUM_BITS-1:0] dvd;    // dividend magnitude, becomes the quotient
  logic [C_NUM_BITS-1:0] bmag;
  logic [C_NUM_BITS-1:0] p;
  logic                  neg_q;
  logic                  neg_r;
  logic                  dz_r;

  logic [C_NUM_BITS-1:0] a_mag;
  logic [C_NUM_BITS-1:0] b_mag;
  logic                  b_zero;
  logic [C_NUM_BITS-1:0] p_next;
  logic                  q_bit;

  assign a_mag  = (SGN && A[C_NUM_BITS-1]) ? -A : A;
  assign b_mag  = (SGN && B[C_NUM_BITS-1]) ? -B : B;
  assign b_zero = (B == '0);

  div_step #(.C_NUM_BITS(C_NUM_BITS)) u_step (
    .p      (p),
    .msb    (dvd[C_NUM_BITS-1]),
    .b      (bmag),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      bmag  <= '0;
      p     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_r  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      Q     <= '0;
      REM   <= '0;
      DZ    <= 1'b0;
    end else if (E) begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            BUSY  <= 1'b1;
            cnt   <= '0;
            p     <= '0;
            bmag  <= b_mag;
            neg_q <= SGN & (A[C_NUM_BITS-1] ^ B[C_NUM_BITS-1]);
            neg_r <= SGN & A[C_NUM_BITS-1];
            dz_r  <= b_zero;
            // On divide-by-zero the raw dividend is kept so it can be
            // returned unchanged as the remainder.
            dvd   <= b_zero ? A : a_mag;
            state <= b_zero ? FIX : RUN;
          end
        end
        RUN: begin
          p   <= p_next;
          dvd <= {dvd[C_NUM_BITS-2:0], q_bit};
          cnt <= cnt + C_CNT_BITS'(1);
          if (cnt == C_LAST) state <= FIX;
        end
        FIX: begin
          Q     <= dz_r ? C_Q_ALL_ONES[C_NUM_BITS-1:0] : (neg_q ? -dvd : dvd);
          REM   <= dz_r ? dvd : (neg_r ? -p : p);
          DZ    <= dz_r;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider at 24 and 8 bits
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] rem;
    logic        dz;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb24[$];
  exp_t sb8[$];
  int   ops24 = 0;
  int   ops8  = 0;

  logic        r24 = 1'b1, e24 = 1'b1, start24 = 1'b0, sgn24 = 1'b0;
  logic [23:0] a24 = '0, b24 = '0;
  logic        busy24, done24, dz24;
  logic [23:0] q24o, rem24o;

  logic        r8 = 1'b1, e8 = 1'b1, start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  q8o, rem8o;

  seq_divider #(.C_NUM_BITS(24)) dut24 (
    .CK(clk), .R(r24), .E(e24), .START(start24), .SGN(sgn24), .A(a24), .B(b24),
    .BUSY(busy24), .DONE(done24), .Q(q24o), .REM(rem24o), .DZ(dz24)
  );

  seq_divider #(.C_NUM_BITS(8)) dut8 (
    .CK(clk), .R(r8), .E(e8), .START(start8), .SGN(sgn8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .Q(q8o), .REM(rem8o), .DZ(dz8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic void ref_div(input int n, input logic sgn, input logic [63:0] a,
                                  input logic [63:0] b, output exp_t e);
    logic [63:0] mask = (64'd1 << n) - 64'd1;
    longint sa, sb;
    e.dz = 1'b0;
    e.lat = 0;
    e.start = 0;
    if ((b & mask) == 64'd0) begin
      e.q = mask; e.rem = a & mask; e.dz = 1'b1;
    end else if (sgn) begin
      sa = a[n-1] ? $signed(a | ~mask) : $signed(a & mask);
      sb = b[n-1] ? $signed(b | ~mask) : $signed(b & mask);
      e.q   = 64'(sa / sb) & mask;
      e.rem = 64'(sa % sb) & mask;
    end else begin
      e.q   = (a & mask) / (b & mask);
      e.rem = (a & mask) % (b & mask);
    end
  endfunction

  // Monitors: pop the scoreboard on each rising DONE.
  logic done24_q = 1'b0, done8_q = 1'b0;
  int   busy_n24 = 0, busy_n8 = 0, done_cnt24 = 0, done_cnt8 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (r24) begin
      busy_n24 = 0; done24_q = 1'b0;
    end else begin
      if (busy24) busy_n24++;
      if (done24 && !done24_q) begin
        done_cnt24++;
        if (sb24.size() == 0) begin
          checks++; errors++;
          $display("FAIL d24_unexpected_done: got DONE with empty scoreboard");
        end else begin
          e = sb24.pop_front();
          chk("d24_q",    64'(q24o),   e.q);
          chk("d24_rem",  64'(rem24o), e.rem);
          chk("d24_dz",   64'(dz24),   64'(e.dz));
          chk("d24_lat",  64'(cyc - e.start), 64'(e.lat));
          chk("d24_busy", 64'(busy_n24), 64'(e.lat));
        end
        busy_n24 = 0;
      end
      done24_q = done24;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (r8) begin
      busy_n8 = 0; done8_q = 1'b0;
    end else begin
      if (busy8) busy_n8++;
      if (done8 && !done8_q) begin
        done_cnt8++;
        if (sb8.size() == 0) begin
          checks++; errors++;
          $display("FAIL d8_unexpected_done: got DONE with empty scoreboard");
        end else begin
          e = sb8.pop_front();
          chk("d8_q",    64'(q8o),   e.q);
          chk("d8_rem",  64'(rem8o), e.rem);
          chk("d8_dz",   64'(dz8),   64'(e.dz));
          chk("d8_lat",  64'(cyc - e.start), 64'(e.lat));
          chk("d8_busy", 64'(busy_n8), 64'(e.lat));
        end
        busy_n8 = 0;
      end
      done8_q = done8;
    end
  end

  // Call at a negedge with the DUT idle and enabled.
  task automatic issue24(input logic sgn, input logic [23:0] a, input logic [23:0] b,
                         input int extra);
    exp_t e;
    ref_div(24, sgn, {40'd0, a}, {40'd0, b}, e);
    e.lat   = ((b == 24'd0) ? 1 : 25) + extra;
    e.start = cyc + 1;
    sgn24 = sgn; a24 = a; b24 = b; start24 = 1'b1;
    sb24.push_back(e);
    ops24++;
  endtask

  // Returns at the negedge where DONE is first seen high.
  task automatic wait24(input int stall_len, input bit poke);
    int n = 1;
    @(negedge clk);
    start24 = 1'b0; a24 = 24'($urandom); b24 = 24'($urandom); sgn24 = ~sgn24;
    while (!done24 && n < 300) begin
      start24 = 1'b0;
      if (poke && n == 5) begin
        start24 = 1'b1; a24 = 24'd999; b24 = 24'd3;
      end
      if (stall_len > 0 && n == 8) e24 = 1'b0;
      if (stall_len > 0 && n == 8 + stall_len) e24 = 1'b1;
      @(negedge clk);
      n++;
    end
    start24 = 1'b0;
    e24 = 1'b1;
    checks++;
    if (!done24) begin
      errors++;
      $display("FAIL d24_timeout: got no DONE within %0d cycles", n);
    end
  endtask

  task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int n = 1;
    ref_div(8, sgn, {56'd0, a}, {56'd0, b}, e);
    e.lat   = (b == 8'd0) ? 1 : 9;
    e.start = cyc + 1;
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    sb8.push_back(e);
    ops8++;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done8) begin
      errors++;
      $display("FAIL d8_timeout: got no DONE within %0d cycles", n);
    end
  endtask

  initial begin
    exp_t e;
    logic [23:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst24_outputs", {13'd0, busy24, done24, dz24, q24o, rem24o}, 64'd0);
    chk("rst8_outputs",  {45'd0, busy8, done8, dz8, q8o, rem8o}, 64'd0);
    r24 = 1'b0; r8 = 1'b0;
    @(negedge clk);

    // Directed 24-bit cases.
    issue24(1'b0, 24'd100, 24'd7, 0);               wait24(0, 1'b0);
    issue24(1'b1, 24'hFFFF9C, 24'd7, 0);            wait24(0, 1'b0);
    issue24(1'b1, 24'd100, 24'hFFFFF9, 0);          wait24(0, 1'b0);
    issue24(1'b1, 24'h800000, 24'hFFFFFF, 0);       wait24(0, 1'b0);

    // Divide-by-zero, then START on the edge where DONE falls.
    issue24(1'b0, 24'h123456, 24'd0, 0);            wait24(0, 1'b0);
    issue24(1'b0, 24'hFFFFFF, 24'd1, 0);            wait24(0, 1'b0);

    // Five-cycle stall mid-RUN, then E low while DONE is high.
    issue24(1'b0, 24'hABCDEF, 24'h000123, 5);       wait24(5, 1'b0);
    e24 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("d24_done_frozen", 64'(done24), 64'd1);
    end
    ref_div(24, 1'b0, 64'hABCDEF, 64'h123, e);
    chk("d24_q_frozen", 64'(q24o), e.q);
    e24 = 1'b1;
    @(negedge clk);
    chk("d24_done_clears", 64'(done24), 64'd0);

    // START during RUN must be ignored.
    issue24(1'b0, 24'd5000, 24'd13, 0);             wait24(0, 1'b1);
    repeat (40) @(negedge clk);
    chk("d24_done_count", 64'(done_cnt24), 64'(ops24));

    // Reset mid-RUN aborts without DONE.
    sgn24 = 1'b0; a24 = 24'd777; b24 = 24'd5; start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
    repeat (10) @(negedge clk);
    r24 = 1'b1;
    #1;
    chk("d24_rst_midrun", {13'd0, busy24, done24, dz24, q24o, rem24o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    r24 = 1'b0;
    repeat (40) @(negedge clk);
    chk("d24_no_done_after_rst", 64'(done_cnt24), 64'(ops24));
    issue24(1'b1, 24'hFFFC18, 24'd33, 0);           wait24(0, 1'b0);

    // Random 24-bit operations.
    for (int i = 0; i < 10; i++) begin
      ra = 24'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 24'd0 : 24'($urandom >> $urandom_range(0, 20));
      issue24(1'($urandom), ra, rb, 0);
      wait24(0, 1'b0);
    end

    // Random 8-bit operations, including the corner operands.
    op8(1'b1, 8'h80, 8'hFF);
    op8(1'b0, 8'hFF, 8'h01);
    for (int i = 0; i < 30; i++) begin
      op8(1'($urandom), 8'($urandom),
          ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("sb24_empty", 64'(sb24.size()), 64'd0);
    chk("sb8_empty",  64'(sb8.size()),  64'd0);
    chk("d8_done_count", 64'(done_cnt8), 64'(ops8));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
